// File: rtl/vscale_hasti_responder.sv
// vscale_hasti_responder
//   AHB-Lite (HASTI) slave with a small word-organised RAM. Every legal
//   transfer takes WAIT_STATES+1 data-phase cycles. Illegal transfers get the
//   two-cycle ERROR response and are counted in a saturating error counter.
//   Address phases can overlap the final data-phase cycle of the previous
//   transfer, so back-to-back transfers run without idle cycles.
//
// Ports
//   hclk, hresetn              clock, asynchronous active-low reset
//   haddr/hwrite/hsize/htrans  address phase, sampled when hready=1
//   hburst/hmastlock/hprot     accepted but unused
//   hwdata                     write data, sampled at the final data-phase edge
//   hrdata                     read data; zero except in the final OKAY read cycle
//   hready/hresp               transfer completion and response
//   err_count                  saturating count of ERROR responses

module vscale_hasti_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int unsigned NUM_WORDS   = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hmastlock,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp,
    output logic [7:0]  err_count
);

    localparam int          AW   = $clog2(NUM_WORDS);
    localparam logic [31:0] SPAN = 32'(NUM_WORDS * 4);
    localparam logic [2:0]  WS   = 3'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    // With no wait states a legal data phase is a single hready=1 cycle. It
    // is spent in IDLE, and this flag marks that the cycle carries a transfer.
    logic          pend_q, pend_d;
    logic [7:0]    err_q, err_d;

    logic [AW-1:0] idx_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic [31:0]   mem_q [NUM_WORDS];

    logic [31:0]   off;
    logic          accept;
    logic          illegal;
    logic          final_ok;
    logic [3:0]    be;
    logic          unused_ok;

    // Offsets below BASE_ADDR wrap to large values and fail the range check.
    assign off     = haddr - BASE_ADDR;
    assign illegal = (hsize > 3'd2)
                  || (hsize == 3'd1 && haddr[0])
                  || (hsize == 3'd2 && haddr[1:0] != 2'b00)
                  || (off >= SPAN);
    assign accept  = hready && htrans[1];

    // Last cycle of an OKAY data phase: the write commits at its closing
    // edge, and read data is driven during it.
    assign final_ok = (state_q == S_WAIT && cnt_q == 3'd0)
                   || (state_q == S_IDLE && pend_q);

    assign unused_ok = ^{hburst, hmastlock, hprot, off[31:AW+2], off[1:0]};

    // Outputs depend only on state, so hready is stable for the whole cycle.
    always_comb begin
        hready = 1'b1;
        hresp  = 1'b0;
        case (state_q)
            S_WAIT:  hready = (cnt_q == 3'd0);
            S_ERR1:  begin hready = 1'b0; hresp = 1'b1; end
            S_ERR2:  hresp = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = 1'b0;
        if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (state_q == S_WAIT && cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end else begin
            // hready=1 here: either pick up a new address phase or go idle.
            state_d = S_IDLE;
            if (accept) begin
                if (illegal) begin
                    state_d = S_ERR1;
                end else if (WS == 3'd0) begin
                    pend_d = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = WS;
                end
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_d == S_ERR1 && err_q != 8'hFF) err_d = err_q + 8'd1;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            pend_q  <= 1'b0;
            err_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            idx_q   <= '0;
            lane_q  <= 2'd0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
        end else if (accept) begin
            idx_q   <= off[AW+1:2];
            lane_q  <= haddr[1:0];
            size_q  <= hsize[1:0];
            write_q <= hwrite;
        end
    end

    // Little-endian byte enables. Only legal transfers reach the data phase,
    // so size_q/lane_q are always naturally aligned here.
    always_comb begin
        case (size_q)
            2'd0:    be = 4'b0001 << lane_q;
            2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < NUM_WORDS; i++) mem_q[i] <= 32'h0;
        end else if (final_ok && write_q) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
        end
    end

    assign hrdata    = (final_ok && !write_q) ? mem_q[idx_q] : 32'h0;
    assign err_count = err_q;

endmodule

// File: doc/vscale_hasti_responder.md
VSCALE_HASTI_RESPONDER -- requirements
Module: vscale_hasti_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_2000, byte address of word 0.
REQ-002 SHALL have parameter NUM_WORDS, default 16, number of 32-bit storage words (power of two, 2..256).
REQ-003 SHALL have parameter WAIT_STATES, default 1, hready-low cycles inserted before each OKAY data-phase completion (0..7).
REQ-004 SHALL provide the following ports, one clock and one asynchronous active-low reset:
  hclk       in   1   clock, all state updates on rising edge
  hresetn    in   1   asynchronous active-low reset
  haddr      in   32  address-phase byte address
  hwrite     in   1   1 = write transfer
  hsize      in   3   0 = byte, 1 = halfword, 2 = word
  hburst     in   3   ignored
  hmastlock  in   1   ignored
  hprot      in   4   ignored
  htrans     in   2   0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
  hwdata     in   32  write data, valid in data phase
  hrdata     out  32  read data
  hready     out  1   transfer-complete / address-accept
  hresp      out  1   0 OKAY, 1 ERROR
  err_count  out  8   saturating count of ERROR responses issued

Function
REQ-005 SHALL accept an address phase when hready=1 and htrans is NONSEQ or SEQ; SHALL register haddr, hwrite and hsize at that edge.
REQ-006 SHALL treat IDLE/BUSY address phases as zero-wait OKAY transfers with no storage access.
REQ-007 SHALL classify an accepted transfer as ERROR if hsize>2, halfword with haddr[0]=1, word with haddr[1:0]!=0, or (haddr-BASE_ADDR) >= NUM_WORDS*4 (unsigned 32-bit).
REQ-008 SHALL implement states IDLE, WAIT, ERR1, ERR2.
REQ-009 IDLE: on accepted legal transfer -> WAIT with wait counter=WAIT_STATES (if WAIT_STATES=0, data phase completes next cycle with hready=1 and no WAIT entry); on accepted illegal transfer -> ERR1; else stay.
REQ-010 WAIT: hready=0, hresp=OKAY while counter>0, counter decrements each cycle; when counter reaches 0, hready=1 for exactly one cycle (final data-phase cycle), then -> IDLE or directly accept the next address phase presented that cycle.
REQ-011 ERR1: hready=0, hresp=1 for one cycle -> ERR2; ERR2: hready=1, hresp=1 for one cycle, then as final data-phase cycle in REQ-010.
REQ-012 Total data-phase length SHALL be WAIT_STATES+1 cycles for OKAY and exactly 2 cycles for ERROR.
REQ-013 Writes SHALL commit at the rising edge ending the final OKAY data-phase cycle, using hwdata sampled then; little-endian byte lanes: byte lane haddr[1:0], halfword lanes {haddr[1],0}..+1, word all lanes; other lanes unchanged.
REQ-014 ERROR writes SHALL not modify storage.
REQ-015 hrdata SHALL equal the full addressed word during the final cycle of an OKAY read and 32'h0 in all other cycles; a read immediately following a write to the same word SHALL return the written data.
REQ-016 err_count SHALL increment by 1 on entry to ERR1, saturating at 8'hFF.
REQ-017 Pipelined back-to-back transfers SHALL be supported: the address phase of transfer N+1 overlaps the final cycle of transfer N.

Reset
REQ-018 On hresetn=0 SHALL asynchronously set state=IDLE, hready=1, hresp=0, hrdata=0, err_count=0, all storage words=0.
REQ-019 Reset asserted mid-transfer SHALL abort it; no write commits; first post-reset transfer behaves as from IDLE.

Verification
REQ-020 Word write 32'hDEADBEEF to 0x2004, then word read 0x2004, WAIT_STATES=1 -> hready low 1 cycle per transfer, read hrdata=32'hDEADBEEF, hresp=0.
REQ-021 After REQ-020, byte write 8'h55 (hwdata 32'h0055_0000) to 0x2006, word read 0x2004 -> 32'hDE55BEEF.
REQ-022 Word read 0x2040 (out of range) -> hready 0 then 1, hresp=1 both cycles, hrdata=0, err_count=1; halfword write to 0x2001 -> ERROR, storage unchanged, err_count=2.
REQ-023 WAIT_STATES=0, back-to-back NONSEQ write 0x2000=32'h1 then read 0x2000 -> hready never low, read returns 32'h1.
REQ-024 hresetn pulsed low during WAIT of a write to 0x2008 -> outputs to reset values immediately; later read 0x2008 returns 32'h0.
REQ-025 256+ illegal transfers -> err_count holds 8'hFF.
